// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder slice (two half adders + OR) reused
// LSB-first over WIDTH clocks, with start/busy/done handshake and held result.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Shared full-adder slice built from two half adders and an OR.
    logic ha1_s, ha1_c, ha2_s, ha2_c, fa_c;
    assign ha1_s = a_sh_q[0] ^ b_sh_q[0];
    assign ha1_c = a_sh_q[0] & b_sh_q[0];
    assign ha2_s = ha1_s ^ carry_q;
    assign ha2_c = ha1_s & carry_q;
    assign fa_c  = ha1_c | ha2_c;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    res_sh_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = {ha2_s, res_sh_q[WIDTH-1:1]};
                carry_d  = fa_c;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = {ha2_s, res_sh_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One add: accept, wait for done, check latency, result and single-cycle pulse.
    task automatic do_add(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                          input string nm);
        logic [W:0] exp_res;
        int lat;
        exp_res = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
        a = ia; b = ib; cin = ic; start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        total++;
        if (lat !== W) $display("FAIL %s latency: got %0d want %0d", nm, lat, W);
        else passed++;
        total++;
        if ({cout, sum} !== exp_res)
            $display("FAIL %s result: got %h want %h", nm, {cout, sum}, exp_res);
        else passed++;
        step();
        total++;
        if (done !== 1'b0) $display("FAIL %s done_width: done=%b want 0", nm, done);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 8'h35; b = 8'h4A; cin = 1'b1;
        step();
        step();
        total++;
        if ({busy, done, sum, cout} !== 11'd0)
            $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b want all 0",
                     busy, done, sum, cout);
        else passed++;
        rst = 1'b0; start = 1'b0;
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_no_start: busy=%b done=%b want 0 0", busy, done);
        else passed++;
    endtask

    task automatic test_basic();
        int bad;
        a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < W; i++) begin
            if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h00) bad++;
            step();
        end
        total++;
        if (bad !== 0) $display("FAIL basic_run: %0d bad RUN cycles want 0", bad);
        else passed++;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'h7F || cout !== 1'b0)
            $display("FAIL basic_done: done=%b busy=%b sum=%h cout=%b want 1 0 7f 0",
                     done, busy, sum, cout);
        else passed++;
        step();
        total++;
        if (done !== 1'b0 || sum !== 8'h7F)
            $display("FAIL basic_after: done=%b sum=%h want 0 7f", done, sum);
        else passed++;
    endtask

    task automatic test_carry();
        do_add(8'hFF, 8'h01, 1'b0, "carry_ff_01");
        do_add(8'hFF, 8'hFF, 1'b1, "carry_ff_ff_c");
    endtask

    task automatic test_ignored_start();
        int lat;
        int extra;
        a = 8'h10; b = 8'h20; cin = 1'b1; start = 1'b1;
        step();
        a = 8'hAA; b = 8'h55; cin = 1'b0;
        step();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        total++;
        if (done !== 1'b1 || sum !== 8'h31 || cout !== 1'b0)
            $display("FAIL ignore_result: done=%b sum=%h cout=%b want 1 31 0", done, sum, cout);
        else passed++;
        start = 1'b1;
        step();
        start = 1'b0;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy !== 1'b0 || done !== 1'b0) extra++;
            step();
        end
        total++;
        if (extra !== 0) $display("FAIL ignore_no_second: %0d active cycles want 0", extra);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int last;
        int ndone;
        int badgap;
        int badsum;
        int overlap;
        last = -1; ndone = 0; badgap = 0; badsum = 0; overlap = 0;
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        step();
        for (int cyc = 1; cyc <= 32; cyc++) begin
            step();
            if (busy === 1'b1 && done === 1'b1) overlap++;
            if (done === 1'b1) begin
                if (sum !== 8'h03 || cout !== 1'b0) badsum++;
                if (last >= 0 && cyc - last !== W + 2) badgap++;
                last = cyc;
                ndone++;
            end
        end
        total++;
        if (ndone !== 3) $display("FAIL b2b_count: got %0d done pulses want 3", ndone);
        else passed++;
        total++;
        if (badgap !== 0 || badsum !== 0 || overlap !== 0)
            $display("FAIL b2b_pulses: badgap=%0d badsum=%0d overlap=%0d want 0 0 0",
                     badgap, badsum, overlap);
        else passed++;
        start = 1'b0;
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_reset_midop();
        int spurious;
        a = 8'h0F; b = 8'h0F; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({busy, done, sum, cout} !== 11'd0)
            $display("FAIL midop_reset: busy=%b done=%b sum=%h cout=%b want all 0",
                     busy, done, sum, cout);
        else passed++;
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        total++;
        if (spurious !== 0) $display("FAIL midop_abort: %0d active cycles want 0", spurious);
        else passed++;
        do_add(8'h0F, 8'h0F, 1'b0, "midop_fresh");
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           gap;
        for (int i = 0; i < 200; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step();
            do_add(ra, rb, rc, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignored_start();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
